// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
//
// Owns the fetch PC and issues in-order requests to instruction memory over a
// request/grant interface. Returned instruction words are tagged with their PC
// and held in a prefetch FIFO, which decode drains over a valid/ready handshake.
// A redirect flushes the FIFO, marks all in-flight responses for discard and
// restarts fetching at the new (word-aligned) PC.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   redirect_i     in   flush and restart at redirect_pc_i
//   redirect_pc_i  in   new fetch PC (bits [1:0] ignored)
//   imem_req_o     out  fetch request
//   imem_addr_o    out  fetch address (current fetch PC)
//   imem_gnt_i     in   request accepted when imem_req_o & imem_gnt_i
//   imem_rvalid_i  in   in-order read response valid
//   imem_rdata_i   in   instruction word of the response
//   if_valid_o     out  instruction available at FIFO head
//   if_ready_i     in   decode accepts the head entry
//   if_instr_o     out  instruction at FIFO head
//   if_pc_o        out  PC of the head instruction
//   if_pc_incr_o   out  if_pc_o + 4
module fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [31:0]     if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_pc_incr_o
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;

    localparam logic [CW:0]     DEPTH_C    = CW1'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [XLEN-1:0] r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]     r_fifo_instr [FIFO_DEPTH];

    logic [CW:0]     w_inflight;
    logic            w_req;
    logic            w_gnt;
    logic            w_resp;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_redirect_pc;

    always_comb begin
        // Credit covers both granted-but-unreturned fetches and buffered
        // entries, so every kept response is guaranteed a FIFO slot. A pop in
        // the same cycle does not free credit, keeping req off the ready path.
        w_inflight    = {1'b0, r_outstanding} + {1'b0, r_count};
        w_req         = !rst && !redirect_i && (w_inflight < DEPTH_C);
        w_gnt         = w_req && imem_gnt_i;
        // A response with nothing outstanding is a protocol violation; ignore it.
        w_resp        = imem_rvalid_i && (r_outstanding != '0);
        w_push        = w_resp && (r_discard == '0) && !redirect_i;
        w_pop         = if_valid_o && if_ready_i;
        w_redirect_pc = redirect_pc_i & ALIGN_MASK;
    end

    assign imem_req_o   = w_req;
    assign imem_addr_o  = r_fetch_pc;
    assign if_valid_o   = (r_count != '0) && !redirect_i;
    assign if_instr_o   = r_fifo_instr[r_rd_ptr];
    assign if_pc_o      = r_fifo_pc[r_rd_ptr];
    assign if_pc_incr_o = r_fifo_pc[r_rd_ptr] + PC_STEP;

    // Control state: PCs, credit counters and FIFO pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_VECTOR;
            r_resp_pc     <= RESET_VECTOR;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            case ({w_gnt, w_resp})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            if (redirect_i) begin
                // Every response still in flight after this cycle belongs to
                // the old stream; one arriving now is already being dropped.
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_discard  <= r_outstanding - CW'(w_resp);
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_gnt) begin
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                end
                if (w_resp && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + PC_STEP;
                    r_wr_ptr  <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // FIFO storage: cleared on reset so the head outputs read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_pc[i]    <= '0;
                r_fifo_instr[i] <= '0;
            end
        end else if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
            r_fifo_instr[r_wr_ptr] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int          XLEN  = 32;
    localparam logic [31:0] RV    = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc_incr_o;

    fetch_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_ready_i    (if_ready_i),
        .if_instr_o    (if_instr_o),
        .if_pc_o       (if_pc_o),
        .if_pc_incr_o  (if_pc_incr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: in-order responses, each not before its due cycle.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          kept;   // granted since the last redirect
    } mem_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    mem_t mem_q[$];
    exp_t exp_q[$];   // instructions decode should receive, in order

    int total = 0;
    int bad   = 0;
    int cyc   = -1;
    int ndeliv = 0;
    int first_valid_cyc = -1;
    bit want_first = 1'b0;
    logic [31:0] first_pc_after = '0;
    logic [31:0] model_pc = RV;

    // stimulus knobs
    int p_gnt = 100, p_rv = 100, p_ready = 100, p_redir = 0;
    int lat_min = 1, lat_max = 1;
    bit force_redir = 1'b0;
    logic [31:0] force_pc = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // One clock cycle of stimulus plus credit/request/address checks.
    task automatic step();
        int   inflight;
        int   kept;
        int   lat;
        bit   redir;
        logic [31:0] rpc;
        mem_t m;
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        kept = 0;
        foreach (mem_q[i]) if (mem_q[i].kept) kept++;
        inflight = mem_q.size() + exp_q.size() - kept;
        chk("credit_cap", 32'(inflight <= DEPTH), 32'd1);

        redir = force_redir || ($urandom_range(999) < p_redir);
        rpc   = force_redir ? force_pc : $urandom;
        force_redir   = 1'b0;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        if (redir) begin
            exp_q.delete();
            foreach (mem_q[i]) mem_q[i].kept = 1'b0;
            model_pc   = rpc & 32'hFFFF_FFFC;
            want_first = 1'b1;
        end

        if_ready_i    = ($urandom_range(99) < p_ready);
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc && $urandom_range(99) < p_rv) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = memf(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        imem_gnt_i = ($urandom_range(99) < p_gnt);
        #1;
        chk("req", 32'(imem_req_o), 32'(!redir && inflight < DEPTH));
        if (imem_req_o && imem_gnt_i) begin
            chk("addr", imem_addr_o, model_pc);
            lat    = lat_min + int'($urandom_range(lat_max - lat_min));
            m.addr = model_pc;
            m.due  = cyc + lat;
            m.kept = 1'b1;
            mem_q.push_back(m);
            e.pc    = model_pc;
            e.instr = memf(model_pc);
            exp_q.push_back(e);
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},    32'(imem_req_o), 32'd0);
        chk({tag, "_addr"},   imem_addr_o, RV);
        chk({tag, "_valid"},  32'(if_valid_o), 32'd0);
        chk({tag, "_instr"},  if_instr_o, 32'd0);
        chk({tag, "_pc"},     if_pc_o, 32'd0);
        chk({tag, "_pcincr"}, if_pc_incr_o, 32'd4);
    endtask

    task automatic cfg(input int g, input int rv, input int rdy, input int rd,
                       input int lmin, input int lmax);
        p_gnt = g; p_rv = rv; p_ready = rdy; p_redir = rd;
        lat_min = lmin; lat_max = lmax;
    endtask

    // Monitor: pops the scoreboard on every decode transfer.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (redirect_i) chk("valid_in_redirect", 32'(if_valid_o), 32'd0);
            if (if_valid_o && if_ready_i) begin
                ndeliv++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (want_first) begin
                    first_pc_after = if_pc_o;
                    want_first     = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_delivery: got pc=%h want none", if_pc_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("if_pc",      if_pc_o,      mon_e.pc);
                    chk("if_instr",   if_instr_o,   mon_e.instr);
                    chk("if_pc_incr", if_pc_incr_o, mon_e.pc + 32'd4);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        redirect_i = 1'b0; redirect_pc_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        if_ready_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Streaming run from reset with single-cycle memory.
        @(negedge clk);
        rst = 1'b0; cyc = -1; want_first = 1'b1; first_valid_cyc = -1; ndeliv = 0;
        cfg(100, 100, 100, 0, 1, 1);
        repeat (20) step();
        @(negedge clk); #1;
        chk("first_valid_cycle", 32'(first_valid_cyc), 32'd2);
        chk("stream_count",      32'(ndeliv), 32'd18);
        chk("first_pc",          first_pc_after, RV);

        // Backpressure: FIFO fills, requests stop.
        cfg(100, 100, 0, 0, 1, 1);
        repeat (10) step();
        @(negedge clk); #1;
        chk("bp_buffered",    32'(exp_q.size()), 32'd4);
        chk("bp_outstanding", 32'(mem_q.size()), 32'd0);
        chk("bp_req",         32'(imem_req_o), 32'd0);
        chk("bp_valid",       32'(if_valid_o), 32'd1);
        cfg(100, 100, 100, 0, 1, 1);
        repeat (10) step();

        // Redirect with fetches in flight on a 3-cycle memory.
        cfg(100, 100, 100, 0, 3, 3);
        repeat (6) step();
        chk("inflight_before_redirect", 32'(mem_q.size() >= 2), 32'd1);
        force_redir = 1'b1; force_pc = 32'h0000_2002;
        step();
        repeat (15) step();
        chk("redirect_first_pc", first_pc_after, 32'h0000_2000);

        // Redirect coincident with responses, then back-to-back redirects.
        cfg(100, 100, 100, 0, 1, 1);
        repeat (5) step();
        force_redir = 1'b1; force_pc = 32'h0000_5554;
        step();
        repeat (5) step();
        force_redir = 1'b1; force_pc = 32'h0000_3000;
        step();
        force_redir = 1'b1; force_pc = 32'h0000_4001;
        step();
        repeat (10) step();
        chk("b2b_redirect_first_pc", first_pc_after, 32'h0000_4000);

        // Random stalls and redirects against the reference model.
        cfg(70, 70, 70, 15, 1, 4);
        repeat (10000) step();

        // Asynchronous reset in mid-stream with the FIFO non-empty.
        cfg(100, 100, 0, 0, 1, 1);
        repeat (10) step();
        chk("pre_reset_valid", 32'(if_valid_o), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        redirect_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; if_ready_i = 1'b0;
        #1;
        check_reset_outputs("midreset");
        mem_q.delete();
        exp_q.delete();
        model_pc = RV;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; cyc = -1; want_first = 1'b1; first_valid_cyc = -1; ndeliv = 0;
        cfg(100, 100, 100, 0, 1, 1);
        repeat (20) step();
        @(negedge clk); #1;
        chk("restart_first_pc",    first_pc_after, RV);
        chk("restart_valid_cycle", 32'(first_valid_cyc), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
